// File: rtl/matrix_c_result_buffer.sv
// Captures a DIM x DIM result matrix from the multiplier, then streams it row-major.
// Optional per-element invalid flag storage: define MATC_INVALID_TRACK_EN.
module matrix_c_result_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DIM        = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  en_WriteMat_C,
  input  logic [3:0]            rowAddr_C,
  input  logic [3:0]            colAddr_C,
  input  logic [DATA_WIDTH-1:0] writeData_C,
  input  logic                  resultIsInvalid,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [3:0]            out_row,
  output logic [3:0]            out_col,
  output logic                  out_last,
  output logic                  out_invalid,
  output logic                  busy,
  output logic                  err_addr
);

  localparam int N  = DIM * DIM;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN
  } state_t;

  state_t state;

  logic [DATA_WIDTH-1:0] mem [N];
  logic [N-1:0]          written;
  logic [CW-1:0]         fill;
  logic [3:0]            ptr_row;
  logic [3:0]            ptr_col;

  logic          in_range;
  logic          wr_hit;
  logic          wr_new;
  logic          at_last;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;

  assign in_range = (rowAddr_C < 4'(DIM)) &&
                    (colAddr_C < 4'(DIM));
  assign wr_idx = IW'(rowAddr_C) * IW'(DIM)
                + IW'(colAddr_C);
  assign rd_idx = IW'(ptr_row) * IW'(DIM)
                + IW'(ptr_col);
  assign wr_hit = (state == CAPTURE) &&
                  en_WriteMat_C && in_range;
  assign wr_new = wr_hit && !written[wr_idx];
  assign at_last = (ptr_row == 4'(DIM - 1)) &&
                   (ptr_col == 4'(DIM - 1));

  assign busy      = (state != IDLE);
  assign out_valid = (state == DRAIN);
  assign out_data  = out_valid ? mem[rd_idx] : '0;
  assign out_row   = out_valid ? ptr_row : 4'd0;
  assign out_col   = out_valid ? ptr_col : 4'd0;
  assign out_last  = out_valid && at_last;

  // Element storage carries no reset; the bitmap tracks what is valid.
  always_ff @(posedge clk) begin
    if (wr_hit) begin
      mem[wr_idx] <= writeData_C;
    end
  end

`ifdef MATC_INVALID_TRACK_EN
  logic inv_mem [N];

  always_ff @(posedge clk) begin
    if (wr_hit) begin
      inv_mem[wr_idx] <= resultIsInvalid;
    end
  end

  assign out_invalid = out_valid && inv_mem[rd_idx];
`else
  logic unused_inv;

  assign unused_inv  = resultIsInvalid;
  assign out_invalid = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      written  <= '0;
      fill     <= '0;
      err_addr <= 1'b0;
      ptr_row  <= 4'd0;
      ptr_col  <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= CAPTURE;
            written  <= '0;
            fill     <= '0;
            err_addr <= 1'b0;
            ptr_row  <= 4'd0;
            ptr_col  <= 4'd0;
          end
        end
        CAPTURE: begin
          if (en_WriteMat_C && !in_range) begin
            err_addr <= 1'b1;
          end
          if (wr_new) begin
            written[wr_idx] <= 1'b1;
            fill            <= fill + CW'(1);
            // The write completing the matrix moves straight to DRAIN.
            if (fill == CW'(N - 1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (at_last) begin
              state   <= IDLE;
              ptr_row <= 4'd0;
              ptr_col <= 4'd0;
            end else if (ptr_col == 4'(DIM - 1)) begin
              ptr_col <= 4'd0;
              ptr_row <= ptr_row + 4'd1;
            end else begin
              ptr_col <= ptr_col + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_c_result_buffer.sv
// Randomized self-checking bench for matrix_c_result_buffer.
// Reference model: last in-range value per element, streamed row-major.
module tb_matrix_c_result_buffer;

  localparam int DW  = 8;
  localparam int DIM = 10;
  localparam int N   = DIM * DIM;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          en = 1'b0;
  logic [3:0]    row = 4'd0;
  logic [3:0]    col = 4'd0;
  logic [DW-1:0] wdata = '0;
  logic          inv = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [3:0]    out_row;
  logic [3:0]    out_col;
  logic          out_last;
  logic          out_invalid;
  logic          busy;
  logic          err_addr;

  typedef struct {
    int r;
    int c;
    int v;
    bit i;
  } wr_t;

  wr_t wq[$];
  int  exp_data[N];
  bit  exp_inv[N];
  bit  exp_err;
  int  n_cmp = 0;
  int  n_bad = 0;

  matrix_c_result_buffer #(.DATA_WIDTH(DW), .DIM(DIM)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .en_WriteMat_C  (en),
    .rowAddr_C      (row),
    .colAddr_C      (col),
    .writeData_C    (wdata),
    .resultIsInvalid(inv),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_row        (out_row),
    .out_col        (out_col),
    .out_last       (out_last),
    .out_invalid    (out_invalid),
    .busy           (busy),
    .err_addr       (err_addr)
  );

  always #5 clk = ~clk;

  task automatic push_wr(input int r, input int c,
                         input int v, input bit i);
    wr_t w;
    w.r = r; w.c = c; w.v = v & 255; w.i = i;
    wq.push_back(w);
    if (r < DIM && c < DIM) begin
      exp_data[r*DIM+c] = v & 255;
      exp_inv[r*DIM+c]  = i;
    end else begin
      exp_err = 1'b1;
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_after_start got=%b want=1", busy);
    end
  endtask

  task automatic run_writes(input bit start_mid);
    for (int i = 0; i < wq.size(); i++) begin
      @(negedge clk);
      en = 1'b0; start = 1'b0;
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      if (i == wq.size() - 1) begin
        n_cmp++;
        if (out_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL early_drain got=%b want=0", out_valid);
        end
      end
      en = 1'b1;
      row = 4'(wq[i].r);
      col = 4'(wq[i].c);
      wdata = DW'(wq[i].v);
      inv = wq[i].i;
      if (start_mid && i == wq.size() / 2) start = 1'b1;
    end
    @(negedge clk);
    en = 1'b0; start = 1'b0; inv = 1'b0;
    wq.delete();
  endtask

  // mode 0: ready high, 1: random ready with stray writes, 2: 1,0,0,1 pattern
  task automatic drain_check(input int mode, input int stop_after);
    int got = 0;
    int k = 0;
    int cyc = 0;
    int vcyc = 0;
    bit stalled = 0;
    bit saw = 0;
    bit r;
    bit exp_i;
    logic [DW+9:0] act, expv, snap;
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    snap = '0;
    while (got < stop_after && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      en = 1'b0;
      if (out_valid) begin
        saw = 1;
        vcyc++;
        act = {out_row, out_col, out_data, out_last, out_invalid};
        if (stalled) begin
          n_cmp++;
          if (act !== snap) begin
            n_bad++;
            $display("FAIL stall_hold got=%h want=%h", act, snap);
          end
        end
`ifdef MATC_INVALID_TRACK_EN
        exp_i = exp_inv[got];
`else
        exp_i = 1'b0;
`endif
        expv = {4'(got / DIM), 4'(got % DIM), DW'(exp_data[got]),
                (got == N - 1), exp_i};
        n_cmp++;
        if (act !== expv) begin
          n_bad++;
          $display("FAIL element_%0d got=%h want=%h", got, act, expv);
        end
        case (mode)
          0: r = 1'b1;
          1: r = 1'($urandom_range(0, 1));
          default: r = pat[k % 4];
        endcase
        k++;
        if (mode == 1) begin
          en = 1'($urandom_range(0, 1));
          row = 4'($urandom_range(0, DIM - 1));
          col = 4'($urandom_range(0, DIM - 1));
          wdata = DW'($urandom);
        end
        out_ready = r;
        if (r) begin
          got++;
          stalled = 0;
        end else begin
          stalled = 1;
          snap = act;
        end
      end else begin
        out_ready = 1'b0;
        if (saw) begin
          n_cmp++;
          n_bad++;
          $display("FAIL valid_dropped got=0 want=1 at %0d", got);
          cyc = 3000;
        end
      end
    end
    n_cmp++;
    if (got != stop_after) begin
      n_bad++;
      $display("FAIL drain_count got=%0d want=%0d", got, stop_after);
    end
    if (stop_after == N) begin
      @(negedge clk);
      out_ready = 1'b0;
      en = 1'b0;
      n_cmp++;
      if ({out_valid, busy} !== 2'b00) begin
        n_bad++;
        $display("FAIL back_to_idle got=%b want=00", {out_valid, busy});
      end
      if (mode == 0) begin
        n_cmp++;
        if (vcyc != N) begin
          n_bad++;
          $display("FAIL throughput got=%0d want=%0d", vcyc, N);
        end
      end
    end
  endtask

  task automatic build_random();
    int perm[N];
    int j, t;
    for (int i = 0; i < N; i++) perm[i] = i;
    for (int i = N - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < N; i++) begin
      if (i > 0 && $urandom_range(0, 7) == 0) begin
        j = perm[$urandom_range(0, i - 1)];
        push_wr(j / DIM, j % DIM, $urandom, 1'($urandom));
      end
      if ($urandom_range(0, 15) == 0) begin
        push_wr($urandom_range(DIM, 15), $urandom_range(0, 15),
                $urandom, 1'b0);
      end
      push_wr(perm[i] / DIM, perm[i] % DIM, $urandom, 1'($urandom));
    end
  endtask

  task automatic check_err(input string name, input bit want);
    n_cmp++;
    if (err_addr !== want) begin
      n_bad++;
      $display("FAIL %s got=%b want=%b", name, err_addr, want);
    end
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({out_valid, out_last, out_invalid, busy, err_addr,
         out_data, out_row, out_col} !== '0) begin
      n_bad++;
      $display("FAIL reset_state got=%b%b%b%b%b %h %h %h want=all zero",
               out_valid, out_last, out_invalid, busy, err_addr,
               out_data, out_row, out_col);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_full_pass();
    exp_err = 0;
    do_start();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) push_wr(r, c, r * 10 + c, 1'b0);
    run_writes(1'b0);
    drain_check(0, N);
  endtask

  task automatic test_rewrite();
    exp_err = 0;
    do_start();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        if (r == 3 && c == 4) push_wr(r, c, 5, 1'b0);
        push_wr(r, c, (r == 3 && c == 4) ? 77 : r * 10 + c, 1'b0);
      end
    run_writes(1'b0);
    drain_check(1, N);
  endtask

  task automatic test_err_addr();
    exp_err = 0;
    do_start();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        push_wr(r, c, $urandom, 1'b0);
        if (r == 0 && c == 5) push_wr(10, 2, 8'hEE, 1'b0);
        if (r == 1 && c == 2) push_wr(0, 12, 8'hAB, 1'b0);
      end
    run_writes(1'b0);
    check_err("err_in_drain", exp_err);
    drain_check(1, N);
    check_err("err_held_idle", 1'b1);
    exp_err = 0;
    do_start();
    check_err("err_cleared", 1'b0);
    build_random();
    run_writes(1'b0);
    drain_check(0, N);
    check_err("err_random", exp_err);
  endtask

  task automatic test_stall();
    exp_err = 0;
    do_start();
    build_random();
    run_writes(1'b0);
    drain_check(2, N);
  endtask

  task automatic test_reset_mid_drain();
    exp_err = 0;
    do_start();
    build_random();
    run_writes(1'b0);
    drain_check(0, 40);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, busy, out_row, out_col} !== '0) begin
      n_bad++;
      $display("FAIL async_reset got=%b%b %h %h want=0 0 0 0",
               out_valid, busy, out_row, out_col);
    end
    out_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    exp_err = 0;
    do_start();
    build_random();
    run_writes(1'b0);
    drain_check(1, N);
  endtask

  task automatic test_invalid();
    exp_err = 0;
    do_start();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        push_wr(r, c, $urandom, (r == 9 && c == 9));
    run_writes(1'b0);
    drain_check(0, N);
  endtask

  task automatic test_random();
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      en = 1'b1; row = 4'd0; col = 4'd0; wdata = DW'($urandom);
      @(negedge clk);
      en = 1'b0;
      exp_err = 0;
      do_start();
      build_random();
      run_writes(1'b1);
      check_err("err_pass", exp_err);
      drain_check(1, N);
    end
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_rewrite();
    test_err_addr();
    test_stall();
    test_reset_mid_drain();
    test_invalid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
